// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: WIDTH-bit word out MSB-first as WIDTH/LANES beats of LANES bits.
// Optional SER_PARITY_EN appends one even-parity beat after the data beats.
//
// state | meaning
// IDLE  | no word held, ready for a new word
// SHIFT | presenting beats of the held word on data_o
module piso_serializer #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [LANES-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             last_o
);

    localparam int BEATS = WIDTH / LANES;
`ifdef SER_PARITY_EN
    localparam int LOAD_CNT = BEATS + 1;
    localparam int CW = $clog2(BEATS + 2);
`else
    localparam int LOAD_CNT = BEATS;
    localparam int CW = $clog2(BEATS + 1);
`endif

    if (WIDTH < 2 || LANES < 1 || (WIDTH % LANES) != 0 || LANES > WIDTH / 2) begin : g_bad_params
        $error("piso_serializer: WIDTH must be >= 2 and a multiple of LANES, 1 <= LANES <= WIDTH/2");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             final_xfer;

    assign valid_o    = (state == SHIFT);
    assign last_o     = valid_o && (cnt == CW'(1));
    // ready_i reaches ready_o only through the final-beat term, so a word can follow without a bubble
    assign ready_o    = reset && ((state == IDLE) || (last_o && ready_i));
    assign load       = valid_i && ready_o;
    assign final_xfer = last_o && ready_i;

`ifdef SER_PARITY_EN
    logic             par;
    logic [LANES-1:0] par_beat;

    always_comb begin
        par_beat          = '0;
        par_beat[LANES-1] = par;
        data_o            = last_o ? par_beat : sreg[WIDTH-1 -: LANES];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            par <= 1'b0;
        end else if (load) begin
            par <= ^data_i;
        end else if (final_xfer) begin
            par <= 1'b0;
        end
    end
`else
    assign data_o = sreg[WIDTH-1 -: LANES];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else if (load) begin
            state <= SHIFT;
            sreg  <= data_i;
            cnt   <= CW'(LOAD_CNT);
        end else if (final_xfer) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else if (valid_o && ready_i) begin
            sreg <= sreg << LANES;
            cnt  <= cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one LANES=1 and one LANES=2 instance, WIDTH=8,
// expected beats queued at word acceptance and popped on each output transfer.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;

    logic [7:0] data_i1, data_i2;
    logic       valid_i1, valid_i2, ready_i1, ready_i2;
    logic       ready_o1, ready_o2, valid_o1, valid_o2, last_o1, last_o2;
    logic [0:0] data_o1;
    logic [1:0] data_o2;

    int checks = 0;
    int failures = 0;

    // entry = {last, data[1:0]}
    logic [2:0] q1[$];
    logic [2:0] q2[$];

    logic       hold1 = 1'b0, hold2 = 1'b0;
    logic [2:0] held1, held2;
    logic       acc2;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .LANES(1)) dut1 (
        .clk(clk), .reset(reset), .data_i(data_i1), .valid_i(valid_i1), .ready_o(ready_o1),
        .data_o(data_o1), .valid_o(valid_o1), .ready_i(ready_i1), .last_o(last_o1)
    );

    piso_serializer #(.WIDTH(8), .LANES(2)) dut2 (
        .clk(clk), .reset(reset), .data_i(data_i2), .valid_i(valid_i2), .ready_o(ready_o2),
        .data_o(data_o2), .valid_o(valid_o2), .ready_i(ready_i2), .last_o(last_o2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
`ifdef SER_PARITY_EN
            q1.push_back({1'b0, 1'b0, w[7-i]});
`else
            q1.push_back({(i == 7), 1'b0, w[7-i]});
`endif
        end
`ifdef SER_PARITY_EN
        q1.push_back({1'b1, 1'b0, ^w});
`endif
    endtask

    task automatic push2(input logic [7:0] w);
        for (int i = 0; i < 4; i++) begin
`ifdef SER_PARITY_EN
            q2.push_back({1'b0, w[7-2*i -: 2]});
`else
            q2.push_back({(i == 3), w[7-2*i -: 2]});
`endif
        end
`ifdef SER_PARITY_EN
        q2.push_back({1'b1, ^w, 1'b0});
`endif
    endtask

    // Inputs are driven just after a negedge; outputs are sampled 2 time units later.
    task automatic tick();
        logic [2:0] e;
        #2;
        acc2 = 1'b0;
        if (reset) begin
            if (hold1) begin
                check("d1_stall_valid", valid_o1, 1);
                check("d1_stall_data_last", {last_o1, 1'b0, data_o1}, held1);
            end
            if (hold2) begin
                check("d2_stall_valid", valid_o2, 1);
                check("d2_stall_data_last", {last_o2, data_o2}, held2);
            end
            if (valid_o1 && ready_i1) begin
                if (q1.size() == 0) check("d1_unexpected_beat", 1, 0);
                else begin
                    e = q1.pop_front();
                    check("d1_data", data_o1, e[0]);
                    check("d1_last", last_o1, e[2]);
                end
            end
            if (valid_o2 && ready_i2) begin
                if (q2.size() == 0) check("d2_unexpected_beat", 1, 0);
                else begin
                    e = q2.pop_front();
                    check("d2_data", data_o2, e[1:0]);
                    check("d2_last", last_o2, e[2]);
                end
            end
            if (valid_i1 && ready_o1) push1(data_i1);
            if (valid_i2 && ready_o2) begin
                push2(data_i2);
                acc2 = 1'b1;
            end
            hold1 = valid_o1 && !ready_i1;
            hold2 = valid_o2 && !ready_i2;
            held1 = {last_o1, 1'b0, data_o1};
            held2 = {last_o2, data_o2};
        end else begin
            q1.delete();
            q2.delete();
            hold1 = 1'b0;
            hold2 = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        valid_i1 = 1'b1; data_i1 = 8'hFF; ready_i1 = 1'b1;
        valid_i2 = 1'b1; data_i2 = 8'hFF; ready_i2 = 1'b1;

        // reset held two cycles with valid_i high
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_ready1", ready_o1, 0);
            check("rst_valid1", valid_o1, 0);
            check("rst_data1", data_o1, 0);
            check("rst_last1", last_o1, 0);
            check("rst_ready2", ready_o2, 0);
            check("rst_valid2", valid_o2, 0);
        end
        valid_i1 = 1'b0;
        valid_i2 = 1'b0;
        reset = 1'b1;
        #1;
        check("post_rst_ready1", ready_o1, 1);
        check("post_rst_valid1", valid_o1, 0);
        check("post_rst_valid2", valid_o2, 0);
        tick();

        // A5 on LANES=1 with ready_i held high
        valid_i1 = 1'b1; data_i1 = 8'hA5;
        tick();
        valid_i1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("a5_valid_run", valid_o1, 1);
            tick();
        end
        check("a5_valid_after", valid_o1, 0);

        // C3 then 3C back-to-back on LANES=2
        valid_i2 = 1'b1; data_i2 = 8'hC3;
        tick();
        data_i2 = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            check("c3_ready_on_last", ready_o2, (i == 3));
            tick();
        end
        valid_i2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("3c_no_gap", valid_o2, 1);
            tick();
        end
        check("3c_valid_after", valid_o2, 0);

        // A5 with downstream stalled for cycles 2-4
        valid_i1 = 1'b1; data_i1 = 8'hA5;
        tick();
        valid_i1 = 1'b0;
        tick();
        ready_i1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_data_hold", data_o1, 0);
            check("bp_last_low", last_o1, 0);
            tick();
        end
        ready_i1 = 1'b1;
        for (int i = 0; i < 7; i++) tick();
`ifdef SER_PARITY_EN
        tick();
`endif
        check("bp_valid_after", valid_o1, 0);

        // reset after three beats of FF drops the word
        valid_i1 = 1'b1; data_i1 = 8'hFF;
        tick();
        valid_i1 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        tick();
        check("midrst_valid", valid_o1, 0);
        check("midrst_ready", ready_o1, 0);
        reset = 1'b1;
        valid_i1 = 1'b1; data_i1 = 8'h01;
        tick();
        valid_i1 = 1'b0;
        for (int i = 0; i < 8; i++) tick();
`ifdef SER_PARITY_EN
        tick();
`endif
        check("w01_valid_after", valid_o1, 0);

        // random traffic and backpressure on LANES=2
        for (int i = 0; i < 80; i++) begin
            if (!valid_i2) begin
                valid_i2 = 1'($urandom_range(0, 1));
                data_i2 = 8'($urandom);
            end
            ready_i2 = 1'($urandom_range(0, 1));
            tick();
            if (acc2) valid_i2 = 1'b0;
        end

        // drain with a bounded wait
        valid_i2 = 1'b0;
        ready_i1 = 1'b1;
        ready_i2 = 1'b1;
        for (int i = 0; i < 40 && (q1.size() != 0 || q2.size() != 0 || valid_o1 || valid_o2); i++) tick();
        check("drain_q1_empty", q1.size(), 0);
        check("drain_q2_empty", q2.size(), 0);
        check("drain_valid2", valid_o2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
